// File: rtl/pwr_switch_seq_if.sv
// pwr_switch_seq_if: groups the pmu_fsm handshake and switch-chain signals of pwr_switch_seq.
// master = the sequencer (drives sw_en, pwr_stable, iso_en, seq_busy, error, sw_state).
// slave  = its environment (drives pwr_gate_en from pmu_fsm and sw_ack from the switch cells).
interface pwr_switch_seq_if #(
    parameter int N_SEG = 4
);
    logic             pwr_gate_en;
    logic [N_SEG-1:0] sw_ack;
    logic [N_SEG-1:0] sw_en;
    logic             pwr_stable;
    logic             iso_en;
    logic             seq_busy;
    logic             error;
    logic [2:0]       sw_state;

    modport master (
        input  pwr_gate_en, sw_ack,
        output sw_en, pwr_stable, iso_en, seq_busy, error, sw_state
    );

    modport slave (
        output pwr_gate_en, sw_ack,
        input  sw_en, pwr_stable, iso_en, seq_busy, error, sw_state
    );
endinterface

// File: rtl/pwr_switch_seq.sv
// pwr_switch_seq: ramps N_SEG header-switch segments on/off one at a time and raises pwr_stable for pmu_fsm.
// Latency: sw_en[0] one cycle after pwr_gate_en=0 is seen in OFF; pwr_stable N_SEG*SEG_DELAY cycles after sw_en[0].
// Backpressure: each segment step waits SEG_DELAY cycles and, with acks checked, for the synchronized ack level.
// Ports: clk; reset (asynchronous, active-high); bus (pwr_switch_seq_if.master):
//   in  pwr_gate_en (1 = gate off), sw_ack[N_SEG] (asynchronous switch acks)
//   out sw_en[N_SEG], pwr_stable, iso_en, seq_busy, error, sw_state[3] -- all registered.
// Build option: PSW_ACK_CHECK_EN -- when defined, sw_ack is synchronized (ack_s) and gates every step,
//   and a missing ack after ACK_TIMEOUT cycles latches FAULT; when undefined, steps are purely timed.
module pwr_switch_seq #(
    parameter int N_SEG       = 4,
    parameter int SEG_DELAY   = 8,
    parameter int ACK_TIMEOUT = 64
) (
    input logic               clk,
    input logic               reset,
    pwr_switch_seq_if.master  bus
);
    localparam int SW = $clog2(N_SEG);
    localparam int CW = $clog2(ACK_TIMEOUT);

    localparam logic [SW-1:0]    SEG_LAST = SW'(N_SEG - 1);
    localparam logic [CW-1:0]    DLY_M1   = CW'(SEG_DELAY - 1);
    localparam logic [CW-1:0]    CNT_MAX  = '1;
    localparam logic [N_SEG-1:0] SEG0_ON  = N_SEG'(1);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_ON        = 3'd2,
        S_ISOLATE   = 3'd3,
        S_RAMP_DOWN = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t           state;
    logic [SW-1:0]    seg;
    logic [CW-1:0]    cnt;
    logic [N_SEG-1:0] sw_en;
    logic             pwr_stable;
    logic             iso_en;
    logic             seq_busy;
    logic             error;

    logic [SW-1:0]    seg_inc;
    logic [SW-1:0]    seg_dec;
    logic             step_up;
    logic             step_dn;
    logic             tmo;

    assign seg_inc = seg + SW'(1);
    assign seg_dec = seg - SW'(1);

`ifdef PSW_ACK_CHECK_EN
    logic [N_SEG-1:0] ack_m;
    logic [N_SEG-1:0] ack_s;

    // Two-flop synchronizer for the asynchronous switch-cell acks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_m <= '0;
            ack_s <= '0;
        end else begin
            ack_m <= bus.sw_ack;
            ack_s <= ack_m;
        end
    end

    assign step_up = ack_s[seg] && (cnt >= DLY_M1);
    assign step_dn = !ack_s[seg] && (cnt >= DLY_M1);
    // Timeout fires only while the ack is still at the wrong level for the current direction.
    assign tmo = (cnt == CW'(ACK_TIMEOUT - 1)) &&
                 (((state == S_RAMP_UP) && !ack_s[seg]) ||
                  ((state == S_RAMP_DOWN) && ack_s[seg]));
`else
    logic ack_unused;
    assign ack_unused = ^bus.sw_ack;

    assign step_up = (cnt >= DLY_M1);
    assign step_dn = (cnt >= DLY_M1);
    assign tmo     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_OFF;
            seg        <= '0;
            cnt        <= '0;
            sw_en      <= '0;
            pwr_stable <= 1'b0;
            iso_en     <= 1'b1;
            seq_busy   <= 1'b0;
            error      <= 1'b0;
        end else begin
            // Free-running saturating counter; every step and state entry below clears it.
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end

            if (tmo) begin
                state      <= S_FAULT;
                sw_en      <= '0;
                iso_en     <= 1'b1;
                pwr_stable <= 1'b0;
                error      <= 1'b1;
                seq_busy   <= 1'b0;
                cnt        <= '0;
            end else begin
                case (state)
                    S_OFF: begin
                        if (!bus.pwr_gate_en) begin
                            state    <= S_RAMP_UP;
                            seg      <= '0;
                            sw_en    <= SEG0_ON;
                            seq_busy <= 1'b1;
                            cnt      <= '0;
                        end
                    end
                    S_RAMP_UP: begin
                        if (step_up) begin
                            cnt <= '0;
                            if (seg != SEG_LAST) begin
                                seg            <= seg_inc;
                                sw_en[seg_inc] <= 1'b1;
                            end else if (!bus.pwr_gate_en) begin
                                state      <= S_ON;
                                pwr_stable <= 1'b1;
                                iso_en     <= 1'b0;
                                seq_busy   <= 1'b0;
                            end else begin
                                // Gate-off requested mid-ramp: skip ON so pwr_stable never pulses.
                                state <= S_ISOLATE;
                            end
                        end
                    end
                    S_ON: begin
                        if (bus.pwr_gate_en) begin
                            state      <= S_ISOLATE;
                            pwr_stable <= 1'b0;
                            iso_en     <= 1'b1;
                            seq_busy   <= 1'b1;
                            cnt        <= '0;
                        end
                    end
                    S_ISOLATE: begin
                        // Let the clamps settle before the first switch opens.
                        if (cnt == DLY_M1) begin
                            state           <= S_RAMP_DOWN;
                            seg             <= SEG_LAST;
                            sw_en[SEG_LAST] <= 1'b0;
                            cnt             <= '0;
                        end
                    end
                    S_RAMP_DOWN: begin
                        if (step_dn) begin
                            cnt <= '0;
                            if (seg != '0) begin
                                seg            <= seg_dec;
                                sw_en[seg_dec] <= 1'b0;
                            end else begin
                                state    <= S_OFF;
                                seq_busy <= 1'b0;
                            end
                        end
                    end
                    S_FAULT: begin
                        // Sticky until reset.
                        state <= S_FAULT;
                    end
                    default: begin
                        state      <= S_OFF;
                        seg        <= '0;
                        cnt        <= '0;
                        sw_en      <= '0;
                        pwr_stable <= 1'b0;
                        iso_en     <= 1'b1;
                        seq_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sw_en      = sw_en;
    assign bus.pwr_stable = pwr_stable;
    assign bus.iso_en     = iso_en;
    assign bus.seq_busy   = seq_busy;
    assign bus.error      = error;
    assign bus.sw_state   = state;
endmodule

// File: tb/tb_pwr_switch_seq.sv
// tb_pwr_switch_seq: directed table-driven bench for pwr_switch_seq with N_SEG=4, SEG_DELAY=8, ACK_TIMEOUT=64.
// The switch cells are modelled as sw_ack = sw_en delayed by 3 clocks (optionally tied low or with one bit stuck).
// Expected values are hand-derived cycle counts relative to the edge that first sees each pwr_gate_en change.
module tb_pwr_switch_seq;
    logic clk;
    logic reset;

    pwr_switch_seq_if #(.N_SEG(4)) bus ();

    pwr_switch_seq #(
        .N_SEG      (4),
        .SEG_DELAY  (8),
        .ACK_TIMEOUT(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch-cell ack model: 0 = sw_en delayed 3 cycles, 1 = tied low, 2 = delayed with bit 2 stuck low.
    int         ack_mode;
    logic [3:0] d1, d2, d3;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else begin
            d1 <= bus.sw_en;
            d2 <= d1;
            d3 <= d2;
        end
    end

    assign bus.sw_ack = (ack_mode == 1) ? 4'b0000 :
                        (ack_mode == 2) ? (d3 & 4'b1011) : d3;

    typedef struct {
        int         adv;
        logic       gate;
        logic [3:0] sw;
        logic       ps;
        logic       iso;
        logic       busy;
        logic       err;
        logic [2:0] st;
    } vec_t;

    vec_t tbl[23];
    int   checks;
    int   failures;
    logic ps_seen;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (bus.pwr_stable) ps_seen = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [3:0] e_sw, input logic e_ps, input logic e_iso,
                         input logic e_busy, input logic e_err, input logic [2:0] e_st);
        checks++;
        if ({bus.sw_en, bus.pwr_stable, bus.iso_en, bus.seq_busy, bus.error, bus.sw_state} !==
            {e_sw, e_ps, e_iso, e_busy, e_err, e_st}) begin
            failures++;
            $display("FAIL %s: got sw_en=%b ps=%b iso=%b busy=%b err=%b st=%0d, want sw_en=%b ps=%b iso=%b busy=%b err=%b st=%0d",
                     name, bus.sw_en, bus.pwr_stable, bus.iso_en, bus.seq_busy, bus.error, bus.sw_state,
                     e_sw, e_ps, e_iso, e_busy, e_err, e_st);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        ps_seen  = 1'b0;
        ack_mode = 0;

        // adv = edges to advance with pwr_gate_en = gate, then compare.
        // Rows 0-7: power-up; 8-16: power-down; 17-22: gate-off raised mid-ramp (0011) and held.
        tbl[0]  = '{1,  1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
        tbl[1]  = '{7,  1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
        tbl[2]  = '{1,  1'b0, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
        tbl[3]  = '{8,  1'b0, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
        tbl[4]  = '{8,  1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
        tbl[5]  = '{7,  1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
        tbl[6]  = '{1,  1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2};
        tbl[7]  = '{5,  1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2};
        tbl[8]  = '{1,  1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3};
        tbl[9]  = '{7,  1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3};
        tbl[10] = '{1,  1'b1, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4};
        tbl[11] = '{8,  1'b1, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4};
        tbl[12] = '{8,  1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4};
        tbl[13] = '{8,  1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4};
        tbl[14] = '{7,  1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4};
        tbl[15] = '{1,  1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[16] = '{3,  1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[17] = '{1,  1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
        tbl[18] = '{8,  1'b0, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
        tbl[19] = '{23, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
        tbl[20] = '{1,  1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3};
        tbl[21] = '{8,  1'b1, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4};
        tbl[22] = '{32, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};

        reset           = 1'b1;
        bus.pwr_gate_en = 1'b1;
        #2;
        check("reset_values", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        tick(2);
        reset = 1'b0;
        tick(3);
        check("off_idle_gated", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

        for (int i = 0; i < 23; i++) begin
            if (i == 17) ps_seen = 1'b0;
            bus.pwr_gate_en = tbl[i].gate;
            tick(tbl[i].adv);
            check($sformatf("vec%0d", i), tbl[i].sw, tbl[i].ps, tbl[i].iso, tbl[i].busy, tbl[i].err, tbl[i].st);
        end

        checks++;
        if (ps_seen !== 1'b0) begin
            failures++;
            $display("FAIL no_stable_on_abort: pwr_stable seen=%b, want 0", ps_seen);
        end

        // Asynchronous reset mid-ramp at 0111.
        bus.pwr_gate_en = 1'b0;
        tick(17);
        check("pre_reset_0111", 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1);
        reset = 1'b1;
        #1;
        check("async_reset", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        bus.pwr_gate_en = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("post_reset_off", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

`ifdef PSW_ACK_CHECK_EN
        // Ack for segment 2 never arrives: FAULT 64 cycles after sw_en[2] rises.
        ack_mode        = 2;
        bus.pwr_gate_en = 1'b0;
        tick(1);
        check("flt_seg0", 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1);
        tick(16);
        check("flt_seg2_on", 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1);
        tick(63);
        check("flt_before_timeout", 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1);
        tick(1);
        check("flt_timeout", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5);
        bus.pwr_gate_en = 1'b1;
        tick(4);
        bus.pwr_gate_en = 1'b0;
        tick(4);
        check("flt_sticky", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5);
        reset = 1'b1;
        #1;
        check("flt_reset", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        bus.pwr_gate_en = 1'b1;
        tick(2);
        reset    = 1'b0;
        ack_mode = 0;
        tick(1);
`else
        // Acks ignored: a ramp with sw_ack tied low still completes on timing alone.
        ack_mode        = 1;
        bus.pwr_gate_en = 1'b0;
        tick(1);
        check("noack_seg0", 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1);
        tick(8);
        check("noack_seg1", 4'b0011, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1);
        tick(16);
        check("noack_seg3", 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1);
        tick(7);
        check("noack_pre_on", 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1);
        tick(1);
        check("noack_on", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
        tick(80);
        check("noack_no_error", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
        ack_mode = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
